// File: rtl/memory_access_if.sv
// Upstream, data-memory and write-back signals of the memory-access stage,
// bundled so the stage and its environment share one connection.
interface memory_access_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  icode_i;
    logic [63:0] valE_i;
    logic [63:0] valA_i;
    logic [63:0] valP_i;
    logic        instr_valid_i;
    logic        imem_error_i;

    logic [63:0] dmem_addr_o;
    logic [7:0]  dmem_wdata_o;
    logic        dmem_we_o;
    logic        dmem_re_o;
    logic [7:0]  dmem_rdata_i;
    logic        dmem_err_i;

    logic        out_valid_o;
    logic [3:0]  icode_o;
    logic [63:0] valE_o;
    logic [63:0] valM_o;
    logic        instr_valid_o;
    logic        imem_error_o;
    logic        dmem_error_o;

    // The memory-access stage itself.
    modport slave (
        input  in_valid_i, icode_i, valE_i, valA_i, valP_i, instr_valid_i, imem_error_i,
        input  dmem_rdata_i, dmem_err_i,
        output in_ready_o, dmem_addr_o, dmem_wdata_o, dmem_we_o, dmem_re_o,
        output out_valid_o, icode_o, valE_o, valM_o, instr_valid_o, imem_error_o, dmem_error_o
    );

    // Execute stage, data memory and write-back seen as one environment.
    modport master (
        output in_valid_i, icode_i, valE_i, valA_i, valP_i, instr_valid_i, imem_error_i,
        output dmem_rdata_i, dmem_err_i,
        input  in_ready_o, dmem_addr_o, dmem_wdata_o, dmem_we_o, dmem_re_o,
        input  out_valid_o, icode_o, valE_o, valM_o, instr_valid_o, imem_error_o, dmem_error_o
    );
endinterface

// File: rtl/memory_access.sv
// Y86-64 memory-access stage: moves one 64-bit word to or from a byte-wide
// data memory, little-endian, one byte per cycle, with range and bus-error checks.
module memory_access #(
    parameter int unsigned DMEM_BYTES = 4096
) (
    input logic            clk_i,
    input logic            rst_i,
    memory_access_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WR, RD, RDLAST, DONE} state_t;

    localparam logic [63:0] ADDR_LIMIT = 64'(DMEM_BYTES) - 64'd8;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [63:0] valm_q, valm_d;
    logic        derr_q, derr_d;
    logic [3:0]  icode_q, icode_d;
    logic [63:0] vale_q, vale_d;
    logic        iv_q, iv_d;
    logic        ime_q, ime_d;

    logic        in_ready_q, out_valid_q, we_q, re_q;
    logic [63:0] maddr_q;
    logic [7:0]  wdata_q;

    logic        is_wr, is_rd;
    logic [63:0] acc_addr, acc_data;
    logic [2:0]  cnt_prev;

    // Access class, address and write data of the instruction on the upstream bus.
    always_comb begin
        is_wr    = 1'b0;
        is_rd    = 1'b0;
        acc_addr = bus.valE_i;
        acc_data = bus.valA_i;
        case (bus.icode_i)
            4'h4, 4'hA: is_wr = 1'b1;
            4'h8: begin
                is_wr    = 1'b1;
                acc_data = bus.valP_i;
            end
            4'h5: is_rd = 1'b1;
            4'h9, 4'hB: begin
                is_rd    = 1'b1;
                acc_addr = bus.valA_i;
            end
            default: ;
        endcase
        if (!bus.instr_valid_i || bus.imem_error_i) begin
            is_wr = 1'b0;
            is_rd = 1'b0;
        end
    end

    assign cnt_prev = cnt_q - 3'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valm_d  = valm_q;
        derr_d  = derr_q;
        icode_d = icode_q;
        vale_d  = vale_q;
        iv_d    = iv_q;
        ime_d   = ime_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    icode_d = bus.icode_i;
                    vale_d  = bus.valE_i;
                    iv_d    = bus.instr_valid_i;
                    ime_d   = bus.imem_error_i;
                    addr_d  = acc_addr;
                    data_d  = acc_data;
                    cnt_d   = 3'd0;
                    valm_d  = 64'd0;
                    derr_d  = 1'b0;
                    if (!is_wr && !is_rd) begin
                        state_d = DONE;
                    end else if (acc_addr > ADDR_LIMIT) begin
                        derr_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = is_wr ? WR : RD;
                    end
                end
            end
            WR: begin
                if (bus.dmem_err_i) begin
                    derr_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD: begin
                // The byte strobed last cycle is on dmem_rdata_i now.
                if (bus.dmem_err_i) begin
                    derr_d  = 1'b1;
                    valm_d  = 64'd0;
                    state_d = DONE;
                end else begin
                    if (cnt_q != 3'd0) valm_d[{cnt_prev, 3'b000} +: 8] = bus.dmem_rdata_i;
                    if (cnt_q == 3'd7) state_d = RDLAST;
                    else               cnt_d   = cnt_q + 3'd1;
                end
            end
            RDLAST: begin
                valm_d[63:56] = bus.dmem_rdata_i;
                state_d       = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus-facing outputs are registered from the next-state values so each
    // strobe appears in the cycle its state is entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 64'd0;
            data_q      <= 64'd0;
            valm_q      <= 64'd0;
            derr_q      <= 1'b0;
            icode_q     <= 4'd0;
            vale_q      <= 64'd0;
            iv_q        <= 1'b0;
            ime_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            maddr_q     <= 64'd0;
            wdata_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valm_q      <= valm_d;
            derr_q      <= derr_d;
            icode_q     <= icode_d;
            vale_q      <= vale_d;
            iv_q        <= iv_d;
            ime_q       <= ime_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            we_q        <= (state_d == WR);
            re_q        <= (state_d == RD);
            maddr_q     <= (state_d == WR || state_d == RD) ? addr_d + {61'd0, cnt_d} : 64'd0;
            wdata_q     <= (state_d == WR) ? data_d[{cnt_d, 3'b000} +: 8] : 8'd0;
        end
    end

    assign bus.in_ready_o    = in_ready_q;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.dmem_we_o     = we_q;
    assign bus.dmem_re_o     = re_q;
    assign bus.dmem_addr_o   = maddr_q;
    assign bus.dmem_wdata_o  = wdata_q;
    assign bus.icode_o       = icode_q;
    assign bus.valE_o        = vale_q;
    assign bus.valM_o        = valm_q;
    assign bus.instr_valid_o = iv_q;
    assign bus.imem_error_o  = ime_q;
    assign bus.dmem_error_o  = derr_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: writes, reads, range and bus errors,
// class-none instructions and reset in mid-operation, against a byte memory.
module tb_memory_access;
    localparam int unsigned DMEM_BYTES = 4096;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0]  mem [0:DMEM_BYTES-1];
    logic [63:0] exp_w;
    int          seen;

    memory_access_if bus ();

    memory_access #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Byte-wide data memory: read data is valid the cycle after the strobe.
    always @(posedge clk_i) begin
        if (bus.dmem_re_o) bus.dmem_rdata_i <= mem[bus.dmem_addr_o[11:0]];
        else               bus.dmem_rdata_i <= 8'hEE;
        if (bus.dmem_we_o) mem[bus.dmem_addr_o[11:0]] <= bus.dmem_wdata_o;
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single edge (cycle 0), then scrambles the inputs.
    task automatic accept(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, input logic iv, input logic ime);
        check("ready before accept", bus.in_ready_o, 1'b1);
        bus.icode_i       = ic;
        bus.valE_i        = e;
        bus.valA_i        = a;
        bus.valP_i        = p;
        bus.instr_valid_i = iv;
        bus.imem_error_i  = ime;
        bus.in_valid_i    = 1'b1;
        step;
        bus.in_valid_i    = 1'b0;
        bus.icode_i       = 4'h0;
        bus.valE_i        = '1;
        bus.valA_i        = '1;
        bus.valP_i        = '1;
        bus.instr_valid_i = 1'b0;
        bus.imem_error_i  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid_i    = 1'b0;
        bus.icode_i       = 4'h0;
        bus.valE_i        = 64'd0;
        bus.valA_i        = 64'd0;
        bus.valP_i        = 64'd0;
        bus.instr_valid_i = 1'b0;
        bus.imem_error_i  = 1'b0;
        bus.dmem_err_i    = 1'b0;
        for (int i = 0; i < int'(DMEM_BYTES); i++) mem[i] = i[7:0];
        exp_w = 64'h0102030405060708;
        for (int k = 0; k < 8; k++) mem[512 + k] = exp_w[8*k +: 8];

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst in_ready", bus.in_ready_o, 1'b1);
        check("rst out_valid", bus.out_valid_o, 1'b0);
        check("rst we", bus.dmem_we_o, 1'b0);
        check("rst re", bus.dmem_re_o, 1'b0);
        check("rst addr", bus.dmem_addr_o, 64'd0);
        check("rst valM", bus.valM_o, 64'd0);
        check("rst dmem_error", bus.dmem_error_o, 1'b0);
        rst_i = 1'b0;

        // rmmovq: eight little-endian byte writes at 0x100..0x107
        accept(4'h4, 64'h100, 64'h1122334455667788, 64'h0, 1'b1, 1'b0);
        check("wr busy", bus.in_ready_o, 1'b0);
        exp_w = 64'h1122334455667788;
        for (int k = 0; k < 8; k++) begin
            check("wr we", bus.dmem_we_o, 1'b1);
            check("wr re", bus.dmem_re_o, 1'b0);
            check("wr addr", bus.dmem_addr_o, 64'h100 + 64'(k));
            check("wr data", bus.dmem_wdata_o, {56'd0, exp_w[8*k +: 8]});
            check("wr no out_valid", bus.out_valid_o, 1'b0);
            step;
        end
        check("wr out_valid c9", bus.out_valid_o, 1'b1);
        check("wr we off", bus.dmem_we_o, 1'b0);
        check("wr dmem_error", bus.dmem_error_o, 1'b0);
        check("wr valM", bus.valM_o, 64'd0);
        check("wr icode_o", bus.icode_o, 64'h4);
        check("wr valE_o", bus.valE_o, 64'h100);
        check("wr instr_valid_o", bus.instr_valid_o, 1'b1);
        step;
        check("wr done one cycle", bus.out_valid_o, 1'b0);

        // popq: eight reads at 0x200..0x207, out_valid in cycle 10
        accept(4'hB, 64'h8, 64'h200, 64'h0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("rd re", bus.dmem_re_o, 1'b1);
            check("rd we", bus.dmem_we_o, 1'b0);
            check("rd addr", bus.dmem_addr_o, 64'h200 + 64'(k));
            step;
        end
        check("rd rdlast no strobe", bus.dmem_re_o, 1'b0);
        check("rd rdlast no out_valid", bus.out_valid_o, 1'b0);
        // Offer an opq during DONE: it must wait for IDLE.
        bus.icode_i = 4'h6; bus.valE_i = 64'h77; bus.instr_valid_i = 1'b1;
        bus.imem_error_i = 1'b0; bus.in_valid_i = 1'b1;
        step;
        check("rd out_valid c10", bus.out_valid_o, 1'b1);
        check("rd valM", bus.valM_o, 64'h0102030405060708);
        check("rd dmem_error", bus.dmem_error_o, 1'b0);
        check("rd valE_o", bus.valE_o, 64'h8);
        check("done not ready", bus.in_ready_o, 1'b0);
        step;
        check("idle after done", bus.in_ready_o, 1'b1);
        check("no accept in done", bus.out_valid_o, 1'b0);
        step;
        bus.in_valid_i = 1'b0;
        check("opq after done", bus.out_valid_o, 1'b1);
        check("opq icode_o", bus.icode_o, 64'h6);
        step;

        // Out of range and the highest legal address
        accept(4'h5, 64'(DMEM_BYTES - 4), 64'h0, 64'h0, 1'b1, 1'b0);
        check("oor out_valid c1", bus.out_valid_o, 1'b1);
        check("oor dmem_error", bus.dmem_error_o, 1'b1);
        check("oor re", bus.dmem_re_o, 1'b0);
        check("oor valM", bus.valM_o, 64'd0);
        step;
        accept(4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 1'b0);
        check("oor wrap out_valid", bus.out_valid_o, 1'b1);
        check("oor wrap dmem_error", bus.dmem_error_o, 1'b1);
        step;
        accept(4'h5, 64'(DMEM_BYTES - 8), 64'h0, 64'h0, 1'b1, 1'b0);
        check("edge re", bus.dmem_re_o, 1'b1);
        check("edge addr", bus.dmem_addr_o, 64'(DMEM_BYTES - 8));
        repeat (9) step;
        check("edge out_valid c10", bus.out_valid_o, 1'b1);
        check("edge dmem_error", bus.dmem_error_o, 1'b0);
        check("edge valM", bus.valM_o, 64'hFFFE_FDFC_FBFA_F9F8);
        step;

        // call with a bus error on byte 3
        accept(4'h8, 64'h300, 64'h0, 64'hAABB, 1'b1, 1'b0);
        exp_w = 64'hAABB;
        for (int k = 0; k < 4; k++) begin
            check("berr we", bus.dmem_we_o, 1'b1);
            check("berr addr", bus.dmem_addr_o, 64'h300 + 64'(k));
            check("berr data", bus.dmem_wdata_o, {56'd0, exp_w[8*k +: 8]});
            if (k == 3) bus.dmem_err_i = 1'b1;
            step;
        end
        bus.dmem_err_i = 1'b0;
        check("berr strobes stop", bus.dmem_we_o, 1'b0);
        check("berr out_valid", bus.out_valid_o, 1'b1);
        check("berr dmem_error", bus.dmem_error_o, 1'b1);
        step;

        // Aborted read leaves valM at zero
        accept(4'h5, 64'h200, 64'h0, 64'h0, 1'b1, 1'b0);
        step;
        step;
        bus.dmem_err_i = 1'b1;
        step;
        bus.dmem_err_i = 1'b0;
        check("rabort out_valid", bus.out_valid_o, 1'b1);
        check("rabort re", bus.dmem_re_o, 1'b0);
        check("rabort dmem_error", bus.dmem_error_o, 1'b1);
        check("rabort valM", bus.valM_o, 64'd0);
        step;

        // Invalid or faulted instructions are class none
        accept(4'h4, 64'h100, 64'h5, 64'h0, 1'b0, 1'b0);
        check("niv out_valid", bus.out_valid_o, 1'b1);
        check("niv we", bus.dmem_we_o, 1'b0);
        check("niv instr_valid_o", bus.instr_valid_o, 1'b0);
        step;
        accept(4'hB, 64'h0, 64'h200, 64'h0, 1'b1, 1'b1);
        check("ime out_valid", bus.out_valid_o, 1'b1);
        check("ime re", bus.dmem_re_o, 1'b0);
        check("ime imem_error_o", bus.imem_error_o, 1'b1);
        step;

        // Reset in cycle 5 of mrmovq
        accept(4'h5, 64'h200, 64'h0, 64'h0, 1'b1, 1'b0);
        repeat (4) step;
        check("mid re before rst", bus.dmem_re_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("mid rst re", bus.dmem_re_o, 1'b0);
        check("mid rst we", bus.dmem_we_o, 1'b0);
        check("mid rst in_ready", bus.in_ready_o, 1'b1);
        check("mid rst out_valid", bus.out_valid_o, 1'b0);
        #2 rst_i = 1'b0;
        seen = 0;
        repeat (12) begin
            step;
            if (bus.out_valid_o) seen++;
        end
        check("mid rst discarded", 64'(seen), 64'd0);
        accept(4'h6, 64'h55, 64'h0, 64'h0, 1'b1, 1'b0);
        check("opq out_valid c1", bus.out_valid_o, 1'b1);
        check("opq icode_o", bus.icode_o, 64'h6);
        check("opq valE_o", bus.valE_o, 64'h55);
        check("opq dmem_error", bus.dmem_error_o, 1'b0);
        step;
        check("opq back to idle", bus.in_ready_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 4096, meaning size of the data memory in bytes; valid addresses are 0..DMEM_BYTES-1.
REQ-002 SHALL have ports, clock and reset first: clk_i in 1 clock; rst_i in 1 asynchronous active-high reset.
REQ-003 SHALL have upstream ports: in_valid_i in 1 execute result present; in_ready_o out 1 block can accept; icode_i in 4; valE_i in 64; valA_i in 64; valP_i in 64; instr_valid_i in 1; imem_error_i in 1.
REQ-004 SHALL have data-memory ports: dmem_addr_o out 64 byte address; dmem_wdata_o out 8 write byte; dmem_we_o out 1 write strobe; dmem_re_o out 1 read strobe; dmem_rdata_i in 8 read byte, valid the cycle after dmem_re_o; dmem_err_i in 1 bus error, sampled in the same cycle as the strobe.
REQ-005 SHALL have write-back ports: out_valid_o out 1; icode_o out 4; valE_o out 64; valM_o out 64; instr_valid_o out 1; imem_error_o out 1; dmem_error_o out 1.

Function
REQ-006 SHALL use states IDLE, WR, RD, RDLAST, DONE; in_ready_o SHALL be 1 only in IDLE.
REQ-007 Acceptance: in IDLE with in_valid_i=1, SHALL register icode_i, valE_i, valA_i, valP_i, instr_valid_i, imem_error_i at that clock edge (cycle 0).
REQ-008 Access class: write for icode 4 (rmmovq), 8 (call), A (pushq); read for icode 5 (mrmovq), 9 (ret), B (popq); none otherwise.
REQ-009 Address: valE for icodes 4, 5, 8, A; valA for icodes 9, B.
REQ-010 Write data: valA for icodes 4, A; valP for icode 8.
REQ-011 With instr_valid_i=0 or imem_error_i=1, SHALL treat the instruction as class none.
REQ-012 Range check at acceptance: if addr > DMEM_BYTES-8 (unsigned 64-bit compare), SHALL perform no bus activity, set dmem_error_o=1, and go to DONE.
REQ-013 Class none: IDLE -> DONE; out_valid_o in cycle 1.
REQ-014 WR: 8 cycles, byte k=0..7 little-endian; dmem_addr_o=addr+k; dmem_wdata_o=data[8k+7:8k]; dmem_we_o=1; then DONE; out_valid_o in cycle 9.
REQ-015 RD: 8 cycles, dmem_re_o=1, dmem_addr_o=addr+k; byte k captured into valM[8k+7:8k] the following cycle; RDLAST captures byte 7 only (no strobe); then DONE; out_valid_o in cycle 10.
REQ-016 dmem_err_i=1 during any strobe cycle SHALL abort: no further strobes, dmem_error_o=1, next state DONE; valM_o for an aborted read SHALL be 0.
REQ-017 DONE SHALL last exactly one cycle with out_valid_o=1, then return to IDLE; no back-to-back acceptance in DONE.
REQ-018 icode_o, valE_o, instr_valid_o, imem_error_o SHALL equal the registered inputs; valM_o SHALL be 0 for write and none classes.
REQ-019 dmem_we_o and dmem_re_o SHALL never both be 1; both SHALL be 0 outside WR/RD.
REQ-020 All outputs SHALL be registered; changes to upstream inputs after acceptance SHALL have no effect until the next IDLE.

Reset
REQ-021 rst_i=1 SHALL immediately force state IDLE and all outputs to 0 except in_ready_o=1, including mid-operation; the in-flight instruction is discarded without out_valid_o.
REQ-022 After rst_i deasserts, the first rising edge with in_valid_i=1 SHALL accept normally.

Verification
REQ-023 rmmovq: icode 4, valE 0x100, valA 0x1122334455667788 -> cycles 1..8 write bytes 88,77,..,11 at 0x100..0x107; out_valid_o cycle 9, dmem_error_o=0.
REQ-024 popq: icode B, valA 0x200, memory holds 0x0102030405060708 -> reads 0x200..0x207 cycles 1..8; out_valid_o cycle 10, valM_o=0x0102030405060708.
REQ-025 Out of range: icode 5, valE DMEM_BYTES-4 -> no strobes; out_valid_o cycle 1, dmem_error_o=1, valM_o=0.
REQ-026 Bus error: call, valE 0x300, dmem_err_i=1 on byte 3 -> strobes for bytes 0..3 only; out_valid_o next cycle with dmem_error_o=1.
REQ-027 Reset mid-read: rst_i asserted in cycle 5 of mrmovq -> strobes drop the same cycle, no out_valid_o, in_ready_o=1; next accepted opq (icode 6) yields out_valid_o one cycle later.
